parking_lot_ctrl_v2: RTL and testbench

Parametrised successor to the single-lot parking controller. It adds configurable capacity, passcode width and value, and timed gate hold. It adds a brute-force lockout after repeated wrong passcodes, plus full/empty/denied status flags. Sits between the gate sensors/keypad front end and the gate actuators; entry and exit gates run as independent FSMs sharing one occupancy counter.

---
 rtl/parking_lot_ctrl_v2_if.sv | 30 +++
 rtl/parking_lot_ctrl_v2.sv | 159 +++++++++++++++
 tb/tb_parking_lot_ctrl_v2.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_lot_ctrl_v2_if.sv
// Gate-controller bus: keypad/sensor requests in, gate drives and status out.
interface parking_lot_ctrl_v2_if #(
  parameter int PASS_W = 8,
  parameter int CNT_W  = 5
);
  logic [PASS_W-1:0] passcode_in;
  logic              enter_req;
  logic              exit_req;
  logic [CNT_W-1:0]  car_count;
  logic              entry_gate_open;
  logic              exit_gate_open;
  logic              lot_full;
  logic              lot_empty;
  logic              entry_denied;
  logic              lockout_active;

  // Front end / bench side
  modport master (
    output passcode_in, enter_req, exit_req,
    input  car_count, entry_gate_open, exit_gate_open,
           lot_full, lot_empty, entry_denied, lockout_active
  );

  // Controller side
  modport slave (
    input  passcode_in, enter_req, exit_req,
    output car_count, entry_gate_open, exit_gate_open,
           lot_full, lot_empty, entry_denied, lockout_active
  );
endinterface

// File: rtl/parking_lot_ctrl_v2.sv
// Parking lot controller: independent entry/exit gate FSMs sharing one
// occupancy counter, with passcode check, timed gate hold and lockout.
module parking_lot_ctrl_v2 #(
  parameter int                CAPACITY         = 20,
  parameter int                CNT_W            = 5,
  parameter int                PASS_W           = 8,
  parameter logic [PASS_W-1:0] PASSCODE         = PASS_W'(8'hFF),
  parameter int                GATE_OPEN_CYCLES = 4,
  parameter int                MAX_FAILS        = 3,
  parameter int                LOCKOUT_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_lot_ctrl_v2_if.slave  bus
);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_OPEN = 2'd1;
  localparam logic [1:0] E_LOCK = 2'd2;
  localparam logic [0:0] X_IDLE = 1'b0;
  localparam logic [0:0] X_OPEN = 1'b1;

  localparam int ET_MAX = (GATE_OPEN_CYCLES > LOCKOUT_CYCLES) ? GATE_OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int ET_W   = $clog2(ET_MAX + 1);
  localparam int XT_W   = $clog2(GATE_OPEN_CYCLES + 1);
  localparam int FC_W   = $clog2(MAX_FAILS + 1);

  localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
  localparam logic [FC_W-1:0]  MAX_FAIL_C = FC_W'(MAX_FAILS);
  localparam logic [ET_W-1:0]  E_GATE_LD  = ET_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [ET_W-1:0]  E_LOCK_LD  = ET_W'(LOCKOUT_CYCLES - 1);
  localparam logic [XT_W-1:0]  X_GATE_LD  = XT_W'(GATE_OPEN_CYCLES - 1);

  logic [1:0]       e_state;
  logic [0:0]       x_state;
  logic [ET_W-1:0]  e_tmr;
  logic [XT_W-1:0]  x_tmr;
  logic [FC_W-1:0]  fail_cnt;
  logic [FC_W-1:0]  fail_inc;
  logic [CNT_W-1:0] count_q;
  logic             eg_q, xg_q, den_q, lock_q;
  logic             code_ok, e_accept, x_accept;

  // Request qualification, all against the pre-edge count
  always_comb begin
    code_ok  = (bus.passcode_in == PASSCODE);
    e_accept = (e_state == E_IDLE) && bus.enter_req && code_ok && (count_q < CAP_C);
    x_accept = (x_state == X_IDLE) && bus.exit_req && (count_q != '0);
    fail_inc = fail_cnt + 1'b1;
  end

  // Entry FSM: accept/deny, gate hold timer, brute-force lockout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_state  <= E_IDLE;
      e_tmr    <= '0;
      fail_cnt <= '0;
      eg_q     <= 1'b0;
      den_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      den_q <= 1'b0;
      case (e_state)
        E_IDLE: begin
          if (bus.enter_req) begin
            if (e_accept) begin
              fail_cnt <= '0;
              e_state  <= E_OPEN;
              eg_q     <= 1'b1;
              e_tmr    <= E_GATE_LD;
            end else begin
              den_q <= 1'b1;
              // Full-lot rejections with a valid code do not count as failures
              if (!code_ok) begin
                fail_cnt <= fail_inc;
                if (fail_inc == MAX_FAIL_C) begin
                  e_state <= E_LOCK;
                  lock_q  <= 1'b1;
                  e_tmr   <= E_LOCK_LD;
                end
              end
            end
          end
        end
        E_OPEN: begin
          if (e_tmr == '0) begin
            e_state <= E_IDLE;
            eg_q    <= 1'b0;
          end else begin
            e_tmr <= e_tmr - 1'b1;
          end
        end
        E_LOCK: begin
          if (e_tmr == '0) begin
            e_state  <= E_IDLE;
            lock_q   <= 1'b0;
            fail_cnt <= '0;
          end else begin
            e_tmr <= e_tmr - 1'b1;
          end
        end
        default: begin
          e_state <= E_IDLE;
          eg_q    <= 1'b0;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  // Exit FSM: accept when occupied, then hold the gate open
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_state <= X_IDLE;
      x_tmr   <= '0;
      xg_q    <= 1'b0;
    end else begin
      case (x_state)
        X_IDLE: begin
          if (x_accept) begin
            x_state <= X_OPEN;
            xg_q    <= 1'b1;
            x_tmr   <= X_GATE_LD;
          end
        end
        default: begin
          if (x_tmr == '0) begin
            x_state <= X_IDLE;
            xg_q    <= 1'b0;
          end else begin
            x_tmr <= x_tmr - 1'b1;
          end
        end
      endcase
    end
  end

  // Shared occupancy counter; simultaneous entry and exit cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({e_accept, x_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.car_count       = count_q;
  assign bus.entry_gate_open = eg_q;
  assign bus.exit_gate_open  = xg_q;
  assign bus.entry_denied    = den_q;
  assign bus.lockout_active  = lock_q;
  assign bus.lot_full        = (count_q == CAP_C);
  assign bus.lot_empty       = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_ctrl_v2.sv
// Testbench for parking_lot_ctrl_v2: vector table plus corner-case sequences,
// every cycle checked against a behavioural scoreboard.
module tb_parking_lot_ctrl_v2;

  localparam int         CAP = 20;
  localparam int         GC  = 4;
  localparam int         MF  = 3;
  localparam int         LC  = 16;
  localparam logic [7:0] PC  = 8'hFF;

  typedef struct packed {
    logic [4:0] cnt;
    logic       eg;
    logic       xg;
    logic       full;
    logic       empty;
    logic       den;
    logic       lk;
  } obs_t;

  typedef struct {
    bit         en;
    logic [7:0] code;
    bit         ex;
    int         gap;
    int         cnt;
    bit         eg;
    bit         xg;
    bit         den;
    bit         lk;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];

  // behavioural model state: 0 idle, 1 open, 2 locked
  int m_cnt, m_es, m_et, m_fails, m_xs, m_xt;
  bit m_den;

  parking_lot_ctrl_v2_if #(.PASS_W(8), .CNT_W(5)) bus ();

  parking_lot_ctrl_v2 #(
    .CAPACITY(CAP), .CNT_W(5), .PASS_W(8), .PASSCODE(PC),
    .GATE_OPEN_CYCLES(GC), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.cnt   = bus.car_count;
    o.eg    = bus.entry_gate_open;
    o.xg    = bus.exit_gate_open;
    o.full  = bus.lot_full;
    o.empty = bus.lot_empty;
    o.den   = bus.entry_denied;
    o.lk    = bus.lockout_active;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_es = 0; m_et = 0; m_fails = 0; m_xs = 0; m_xt = 0; m_den = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.cnt   = 5'(m_cnt);
    o.eg    = (m_es == 1);
    o.xg    = (m_xs == 1);
    o.full  = (m_cnt == CAP);
    o.empty = (m_cnt == 0);
    o.den   = m_den;
    o.lk    = (m_es == 2);
    return o;
  endfunction

  // One clock edge of the specified behaviour
  task automatic model_edge(input bit en, input logic [7:0] code, input bit ex);
    int pre;
    bit ea, xa;
    pre = m_cnt; ea = 0; xa = 0; m_den = 0;
    if (m_es == 0) begin
      if (en) begin
        if (code == PC && pre < CAP) begin
          ea = 1; m_fails = 0; m_es = 1; m_et = GC;
        end else if (code == PC) begin
          m_den = 1;
        end else begin
          m_den = 1; m_fails++;
          if (m_fails == MF) begin m_es = 2; m_et = LC; end
        end
      end
    end else begin
      m_et--;
      if (m_et == 0) begin
        if (m_es == 2) m_fails = 0;
        m_es = 0;
      end
    end
    if (m_xs == 0) begin
      if (ex && pre > 0) begin xa = 1; m_xs = 1; m_xt = GC; end
    end else begin
      m_xt--;
      if (m_xt == 0) m_xs = 0;
    end
    m_cnt = pre + int'(ea) - int'(xa);
  endtask

  // Drive one cycle of stimulus, predict, then compare just after the edge
  task automatic cycle(input bit en, input logic [7:0] code, input bit ex);
    obs_t e, g;
    @(negedge clk);
    bus.enter_req   = en;
    bus.passcode_in = code;
    bus.exit_req    = ex;
    model_edge(en, code, ex);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    g = sample();
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL scoreboard @%0t: got cnt=%0d eg=%b xg=%b full=%b empty=%b den=%b lk=%b expected cnt=%0d eg=%b xg=%b full=%b empty=%b den=%b lk=%b",
               $time, g.cnt, g.eg, g.xg, g.full, g.empty, g.den, g.lk,
               e.cnt, e.eg, e.xg, e.full, e.empty, e.den, e.lk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " car_count"},       int'(bus.car_count), 0);
    chk({tag, " entry_gate_open"}, int'(bus.entry_gate_open), 0);
    chk({tag, " exit_gate_open"},  int'(bus.exit_gate_open), 0);
    chk({tag, " entry_denied"},    int'(bus.entry_denied), 0);
    chk({tag, " lockout_active"},  int'(bus.lockout_active), 0);
    chk({tag, " lot_empty"},       int'(bus.lot_empty), 1);
    chk({tag, " lot_full"},        int'(bus.lot_full), 0);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    //           en  code   ex gap cnt eg xg den lk
    vecs[0]  = '{1, 8'hFF, 0, 10, 1, 1, 0, 0, 0};
    vecs[1]  = '{1, 8'hFE, 0, 10, 1, 0, 0, 1, 0};
    vecs[2]  = '{1, 8'hFE, 0, 10, 1, 0, 0, 1, 0};
    vecs[3]  = '{1, 8'hFE, 0,  5, 1, 0, 0, 1, 1};
    vecs[4]  = '{1, 8'hFF, 0, 15, 1, 0, 0, 0, 1};
    vecs[5]  = '{1, 8'hFF, 0, 10, 2, 1, 0, 0, 0};
    vecs[6]  = '{1, 8'hFE, 0, 10, 2, 0, 0, 1, 0};
    vecs[7]  = '{1, 8'hFE, 0, 10, 2, 0, 0, 1, 0};
    vecs[8]  = '{1, 8'hFF, 0, 10, 3, 1, 0, 0, 0};
    vecs[9]  = '{1, 8'hFE, 0, 10, 3, 0, 0, 1, 0};
    vecs[10] = '{1, 8'h00, 0, 10, 3, 0, 0, 1, 0};
    vecs[11] = '{0, 8'h00, 1, 10, 2, 0, 1, 0, 0};
    vecs[12] = '{0, 8'h00, 1, 10, 1, 0, 1, 0, 0};
    vecs[13] = '{1, 8'hFF, 1, 10, 1, 1, 1, 0, 0};
    vecs[14] = '{0, 8'h00, 1, 10, 0, 0, 1, 0, 0};
    vecs[15] = '{0, 8'h00, 1, 10, 0, 0, 0, 0, 0};

    bus.enter_req = 1'b0; bus.exit_req = 1'b0; bus.passcode_in = 8'h00;
    model_reset();
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 16; v++) begin
      cycle(vecs[v].en, vecs[v].code, vecs[v].ex);
      chk($sformatf("vec%0d car_count", v), int'(bus.car_count), vecs[v].cnt);
      chk($sformatf("vec%0d entry_gate_open", v), int'(bus.entry_gate_open), int'(vecs[v].eg));
      chk($sformatf("vec%0d exit_gate_open", v), int'(bus.exit_gate_open), int'(vecs[v].xg));
      chk($sformatf("vec%0d entry_denied", v), int'(bus.entry_denied), int'(vecs[v].den));
      chk($sformatf("vec%0d lockout_active", v), int'(bus.lockout_active), int'(vecs[v].lk));
      idle(vecs[v].gap);
    end

    // Fill the lot to capacity
    for (int i = 0; i < CAP; i++) begin
      cycle(1'b1, PC, 1'b0);
      idle(5);
    end
    chk("fill car_count", int'(bus.car_count), 20);
    chk("fill lot_full", int'(bus.lot_full), 1);

    // Valid code at full: denied, no lockout progression
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, PC, 1'b0);
      chk("full deny entry_denied", int'(bus.entry_denied), 1);
      chk("full deny car_count", int'(bus.car_count), 20);
      idle(3);
      chk("full deny lockout_active", int'(bus.lockout_active), 0);
    end

    // Simultaneous entry and exit at full: exit only
    cycle(1'b1, PC, 1'b1);
    chk("full both car_count", int'(bus.car_count), 19);
    chk("full both entry_denied", int'(bus.entry_denied), 1);
    chk("full both exit_gate_open", int'(bus.exit_gate_open), 1);
    chk("full both entry_gate_open", int'(bus.entry_gate_open), 0);
    chk("full both lot_full", int'(bus.lot_full), 0);
    idle(5);

    // Drain to 5, then simultaneous accepted entry and exit
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      idle(5);
    end
    chk("drain car_count", int'(bus.car_count), 5);
    cycle(1'b1, PC, 1'b1);
    chk("both car_count", int'(bus.car_count), 5);
    idle(3);
    chk("both entry_gate_open last", int'(bus.entry_gate_open), 1);
    chk("both exit_gate_open last", int'(bus.exit_gate_open), 1);
    idle(1);
    chk("both entry_gate_closed", int'(bus.entry_gate_open), 0);
    chk("both exit_gate_closed", int'(bus.exit_gate_open), 0);

    // Reset while the entry gate is open
    cycle(1'b1, PC, 1'b0);
    idle(1);
    async_reset("reset mid-open");

    // Exit request on an empty lot
    cycle(1'b0, 8'h00, 1'b1);
    chk("empty exit car_count", int'(bus.car_count), 0);
    chk("empty exit gate", int'(bus.exit_gate_open), 0);
    idle(2);

    // Reset while locked out
    for (int i = 0; i < MF; i++) begin
      cycle(1'b1, 8'hFE, 1'b0);
      idle(3);
    end
    chk("pre-reset lockout_active", int'(bus.lockout_active), 1);
    async_reset("reset mid-lock");
    cycle(1'b1, PC, 1'b0);
    chk("post-reset entry car_count", int'(bus.car_count), 1);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
